// File: rtl/mac_sched.sv
// Two-requester scheduler that time-shares one free-running 16x16/32-bit MAC:
// grants a job, clears the accumulator, streams the owner's pairs, returns the sum.
module mac_sched #(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [2*LEN_W-1:0] req_len,
  output logic [1:0]         gnt,
  input  logic [1:0]         op_valid,
  output logic [1:0]         op_ready,
  input  logic [31:0]        op_a,
  input  logic [31:0]        op_b,
  output logic               mac_clr,
  output logic [15:0]        mac_a,
  output logic [15:0]        mac_b,
  input  logic [31:0]        mac_acc,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [31:0]        res_data,
  output logic               res_id
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic             owner_q, owner_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] count_inc;
  logic [31:0]      res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             win;
  logic [15:0]      own_a, own_b;

  assign own_a     = owner_q ? op_a[31:16] : op_a[15:0];
  assign own_b     = owner_q ? op_b[31:16] : op_b[15:0];
  assign count_inc = count_q + LEN_W'(1);

  assign res_valid = (state_q == DONE);
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    len_d      = len_q;
    count_d    = count_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    gnt        = 2'b00;
    op_ready   = 2'b00;
    mac_clr    = 1'b0;
    mac_a      = '0;
    mac_b      = '0;
    win        = rr_q;

    case (state_q)
      IDLE: begin
        // gnt is combinational, so keep it quiet while reset is held
        if (req != 2'b00 && !reset) begin
          win     = (req == 2'b11) ? rr_q : req[1];
          gnt     = win ? 2'b10 : 2'b01;
          owner_d = win;
          len_d   = win ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];
          count_d = '0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        mac_clr = 1'b1;
        state_d = (len_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        op_ready = owner_q ? 2'b10 : 2'b01;
        if (op_valid[owner_q]) begin
          mac_a   = own_a;
          mac_b   = own_b;
          count_d = count_inc;
          if (count_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        res_data_d = mac_acc;
        res_id_d   = owner_q;
        state_d    = DONE;
      end
      DONE: begin
        if (res_ready) begin
          rr_d    = ~owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      owner_q    <= 1'b0;
      len_q      <= '0;
      count_q    <= '0;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      len_q      <= len_d;
      count_q    <= count_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

endmodule
